// File: rtl/crc32_serial_pkg.sv
// Shared definitions for the bit-serial CRC-32 controller.
//   state_e    : FSM state encoding (IDLE, SHIFT, FLUSH, DONE)
//   CRC32_POLY : default feedback polynomial (the x^32 term is implicit)
//   crc_step   : one-bit LFSR advance of the CRC register
package crc32_serial_pkg;

  localparam logic [31:0] CRC32_POLY = 32'h04C11DB7;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StFlush,
    StDone
  } state_e;

  // Shift the next message bit in at the LSB; fold the polynomial back in
  // when the bit leaving the top of the register is set.
  function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic b,
                                           input logic [31:0] poly);
    crc_step = {crc[30:0], b} ^ (crc[31] ? poly : 32'h0);
  endfunction

endpackage

// File: rtl/crc32_serial_ctrl.sv
// Bit-serial CRC-32 engine with a byte-wide valid/ready input.
// Each accepted byte is folded into the CRC one bit per clock, MSB first.
// After the last byte the register is optionally augmented with 32 zero bits,
// then the result is flagged for one cycle and held in IDLE.
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_data       byte to fold in, sampled on accept (i_valid && o_ready)
//   i_valid      i_data / i_last are valid
//   i_last       current byte ends the frame
//   o_ready      a byte is accepted this cycle if i_valid is high
//   i_abort      synchronous frame abort, overrides everything else
//   o_crc        CRC register contents
//   o_crc_valid  one-cycle pulse when o_crc holds a finished frame CRC
//   o_busy       high whenever the FSM is not idle
module crc32_serial_ctrl
  import crc32_serial_pkg::*;
#(
  parameter logic [31:0] POLYNOMIAL = CRC32_POLY,
  parameter logic [31:0] INIT       = 32'h0,
  parameter bit          AUGMENT    = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  i_data,
  input  logic        i_valid,
  input  logic        i_last,
  output logic        o_ready,
  input  logic        i_abort,
  output logic [31:0] o_crc,
  output logic        o_crc_valid,
  output logic        o_busy
);

  state_e      r_state, w_state_next;
  logic [31:0] r_crc, w_crc_next;
  logic [7:0]  r_byte, w_byte_next;
  logic        r_last, w_last_next;
  logic [2:0]  r_bit_cnt, w_bit_cnt_next;
  logic [5:0]  r_flush_cnt, w_flush_cnt_next;

  logic w_bit_is_last;
  logic w_shift_bit;
  logic w_accept;

  assign w_bit_is_last = (r_bit_cnt == 3'd7);
  // Bit-count 0 selects i_data[7], so the byte goes out MSB first.
  assign w_shift_bit   = r_byte[3'd7 - r_bit_cnt];

  // Ready in SHIFT only on the final bit of a non-last byte, so the next byte
  // loads on the same edge that shifts bit 0 of the current one.
  assign o_ready  = (r_state == StIdle) ||
                    ((r_state == StShift) && w_bit_is_last && !r_last);
  assign w_accept = i_valid && o_ready;

  assign o_crc  = r_crc;
  assign o_busy = (r_state != StIdle);

  always_comb begin
    w_state_next     = r_state;
    w_crc_next       = r_crc;
    w_byte_next      = r_byte;
    w_last_next      = r_last;
    w_bit_cnt_next   = r_bit_cnt;
    w_flush_cnt_next = r_flush_cnt;
    o_crc_valid      = 1'b0;

    if (i_abort) begin
      // Drop the frame: CRC is left as-is and any same-cycle accept is lost.
      w_state_next = StIdle;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            w_crc_next       = INIT;
            w_byte_next      = i_data;
            w_last_next      = i_last;
            w_bit_cnt_next   = 3'd0;
            w_flush_cnt_next = 6'd0;
            w_state_next     = StShift;
          end
        end

        StShift: begin
          if (!w_bit_is_last) begin
            w_crc_next     = crc_step(r_crc, w_shift_bit, POLYNOMIAL);
            w_bit_cnt_next = r_bit_cnt + 3'd1;
          end else if (r_last) begin
            w_crc_next       = crc_step(r_crc, w_shift_bit, POLYNOMIAL);
            w_bit_cnt_next   = 3'd0;
            w_flush_cnt_next = 6'd0;
            w_state_next     = AUGMENT ? StFlush : StDone;
          end else if (w_accept) begin
            w_crc_next     = crc_step(r_crc, w_shift_bit, POLYNOMIAL);
            w_byte_next    = i_data;
            w_last_next    = i_last;
            w_bit_cnt_next = 3'd0;
          end
          // Otherwise stall on bit 7 without stepping until the next byte.
        end

        StFlush: begin
          w_crc_next       = crc_step(r_crc, 1'b0, POLYNOMIAL);
          w_flush_cnt_next = r_flush_cnt + 6'd1;
          if (r_flush_cnt == 6'd31) begin
            w_flush_cnt_next = 6'd0;
            w_state_next     = StDone;
          end
        end

        StDone: begin
          o_crc_valid  = 1'b1;
          w_state_next = StIdle;
        end

        default: w_state_next = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_crc       <= INIT;
      r_byte      <= 8'h00;
      r_last      <= 1'b0;
      r_bit_cnt   <= 3'd0;
      r_flush_cnt <= 6'd0;
    end else begin
      r_state     <= w_state_next;
      r_crc       <= w_crc_next;
      r_byte      <= w_byte_next;
      r_last      <= w_last_next;
      r_bit_cnt   <= w_bit_cnt_next;
      r_flush_cnt <= w_flush_cnt_next;
    end
  end

endmodule

// File: tb/tb_crc32_serial_ctrl.sv
// Self-checking bench for crc32_serial_ctrl. Instance A uses AUGMENT=1,
// instance B uses AUGMENT=0; both share clock, reset, data, last and abort.
`timescale 1ns/1ps
module tb_crc32_serial_ctrl;

  localparam logic [32:0] PFull = 33'h1_04C1_1DB7;

  logic        clk;
  logic        rst_n;
  logic [7:0]  data;
  logic        last;
  logic        abort;
  logic        valid_a, valid_b;
  logic        rdy_a, rdy_b;
  logic [31:0] crc_a, crc_b;
  logic        cv_a, cv_b;
  logic        busy_a, busy_b;

  int n_cmp;
  int n_err;
  int cyc;

  int          acc_cyc[$];
  logic [31:0] got_crc;
  int          got_lat;
  bit          got_timeout;
  logic        got_cv_after;
  logic        got_busy_after;
  logic [31:0] got_crc_after;

  crc32_serial_ctrl #(.AUGMENT(1'b1)) dut_a (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_data     (data),
    .i_valid    (valid_a),
    .i_last     (last),
    .o_ready    (rdy_a),
    .i_abort    (abort),
    .o_crc      (crc_a),
    .o_crc_valid(cv_a),
    .o_busy     (busy_a)
  );

  crc32_serial_ctrl #(.AUGMENT(1'b0)) dut_b (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_data     (data),
    .i_valid    (valid_b),
    .i_last     (last),
    .o_ready    (rdy_b),
    .i_abort    (abort),
    .o_crc      (crc_b),
    .o_crc_valid(cv_b),
    .o_busy     (busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (got running, required finished)");
    $fatal(1);
  end

  // Reference: message bits (MSB first per byte), optionally followed by 32
  // zeros, reduced modulo the degree-32 generator by polynomial long division.
  function automatic logic [31:0] model_crc(input logic [7:0] m[$], input bit aug);
    logic [32:0] r;
    bit bits[$];
    r = '0;
    foreach (m[i]) for (int k = 7; k >= 0; k--) bits.push_back(m[i][k]);
    if (aug) for (int k = 0; k < 32; k++) bits.push_back(1'b0);
    foreach (bits[j]) begin
      r = {r[31:0], bits[j]};
      if (r[32]) r = r ^ PFull;
    end
    return r[31:0];
  endfunction

  function automatic logic rdy(input bit sel);
    return sel ? rdy_b : rdy_a;
  endfunction
  function automatic logic cv(input bit sel);
    return sel ? cv_b : cv_a;
  endfunction

  task automatic set_valid(input bit sel, input logic v);
    if (sel) valid_b = v;
    else valid_a = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one frame on the selected instance, recording accept cycles, the
  // finished CRC, and latency from last accept to the o_crc_valid edge.
  task automatic run_frame(input bit sel, input logic [7:0] msg[$], input int max_gap);
    int t;
    int gap;
    acc_cyc.delete();
    got_timeout = 1'b0;
    got_crc     = '0;
    got_lat     = -1;
    for (int i = 0; i < msg.size(); i++) begin
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      repeat (gap) tick();
      data = msg[i];
      last = (i == msg.size() - 1);
      set_valid(sel, 1'b1);
      t = 0;
      while (!rdy(sel) && t < 200) begin
        tick();
        t++;
      end
      if (!rdy(sel)) begin
        got_timeout = 1'b1;
        set_valid(sel, 1'b0);
        return;
      end
      tick();
      acc_cyc.push_back(cyc);
      set_valid(sel, 1'b0);
      last = 1'b0;
      data = 8'($urandom);
    end
    t = 0;
    while (!cv(sel) && t < 200) begin
      tick();
      t++;
    end
    if (!cv(sel)) begin
      got_timeout = 1'b1;
      return;
    end
    got_crc = sel ? crc_b : crc_a;
    // DONE seen after edge E means the pulse is sampled by edge E+1.
    got_lat = cyc - acc_cyc[acc_cyc.size() - 1] + 1;
    tick();
    got_cv_after   = cv(sel);
    got_busy_after = sel ? busy_b : busy_a;
    got_crc_after  = sel ? crc_b : crc_a;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_cmp++;
    if (busy_a !== 1'b0 || cv_a !== 1'b0 || crc_a !== 32'h0) begin
      n_err++;
      $display("FAIL reset_a: busy=%b cv=%b crc=%h, required 0 0 00000000", busy_a, cv_a, crc_a);
    end
    n_cmp++;
    if (busy_b !== 1'b0 || cv_b !== 1'b0 || crc_b !== 32'h0) begin
      n_err++;
      $display("FAIL reset_b: busy=%b cv=%b crc=%h, required 0 0 00000000", busy_b, cv_b, crc_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (rdy_a !== 1'b1 || rdy_b !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready: got %b/%b, required 1/1", rdy_a, rdy_b);
    end
  endtask

  task automatic test_known();
    logic [7:0]  bytes[3] = '{8'h01, 8'h02, 8'h00};
    logic [31:0] exp[3]   = '{32'h04C11DB7, 32'h09823B6E, 32'h00000000};
    logic [7:0]  msg[$];
    for (int i = 0; i < 3; i++) begin
      msg = '{bytes[i]};
      run_frame(1'b0, msg, 0);
      n_cmp++;
      if (got_timeout || got_crc !== exp[i]) begin
        n_err++;
        $display("FAIL known_crc[%0h]: got %h (timeout=%0d), required %h",
                 bytes[i], got_crc, got_timeout, exp[i]);
      end
      n_cmp++;
      if (got_lat !== 41) begin
        n_err++;
        $display("FAIL known_latency[%0h]: got %0d, required 41", bytes[i], got_lat);
      end
      n_cmp++;
      if (got_cv_after !== 1'b0 || got_busy_after !== 1'b0 || got_crc_after !== exp[i]) begin
        n_err++;
        $display("FAIL known_after[%0h]: cv=%b busy=%b crc=%h, required 0 0 %h",
                 bytes[i], got_cv_after, got_busy_after, got_crc_after, exp[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] msg[$];
    msg = '{8'h00, 8'h01};
    run_frame(1'b0, msg, 0);
    n_cmp++;
    if (got_timeout || acc_cyc.size() != 2 || (acc_cyc[1] - acc_cyc[0]) != 8) begin
      n_err++;
      $display("FAIL b2b_spacing: got %0d cycles between accepts, required 8",
               (acc_cyc.size() == 2) ? acc_cyc[1] - acc_cyc[0] : -1);
    end
    n_cmp++;
    if (got_crc !== 32'h04C11DB7) begin
      n_err++;
      $display("FAIL b2b_crc: got %h, required 04c11db7", got_crc);
    end
  endtask

  task automatic test_no_augment();
    logic [7:0] msg[$];
    msg = '{8'h01};
    run_frame(1'b1, msg, 0);
    n_cmp++;
    if (got_timeout || got_crc !== 32'h00000001) begin
      n_err++;
      $display("FAIL noaug_crc: got %h, required 00000001", got_crc);
    end
    n_cmp++;
    if (got_lat !== 9) begin
      n_err++;
      $display("FAIL noaug_latency: got %0d, required 9", got_lat);
    end
  endtask

  // Stall on bit 7 of a non-last byte, then junk on i_valid while not ready.
  task automatic test_stall();
    logic [7:0]  msg[$];
    logic [31:0] exp;
    int          acc2;
    int          t;
    data = 8'h81;
    last = 1'b0;
    valid_a = 1'b1;
    tick();
    valid_a = 1'b0;
    repeat (7) tick();
    // Seven bits 1,0,0,0,0,0,0 shifted in from zero.
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (rdy_a !== 1'b1 || crc_a !== 32'h00000040) begin
        n_err++;
        $display("FAIL stall_hold[%0d]: ready=%b crc=%h, required 1 00000040", i, rdy_a, crc_a);
      end
      tick();
    end
    data = 8'h00;
    last = 1'b1;
    valid_a = 1'b1;
    tick();
    acc2 = cyc;
    for (int i = 0; i < 20; i++) begin
      data = 8'($urandom);
      last = 1'($urandom);
      tick();
      n_cmp++;
      if (rdy_a !== 1'b0) begin
        n_err++;
        $display("FAIL stall_not_ready[%0d]: got %b, required 0", i, rdy_a);
      end
    end
    valid_a = 1'b0;
    last = 1'b0;
    t = 0;
    while (!cv_a && t < 100) begin
      tick();
      t++;
    end
    msg = '{8'h81, 8'h00};
    exp = model_crc(msg, 1'b1);
    n_cmp++;
    if (!cv_a || crc_a !== exp || (cyc - acc2 + 1) != 41) begin
      n_err++;
      $display("FAIL stall_result: cv=%b crc=%h lat=%0d, required 1 %h 41",
               cv_a, crc_a, cyc - acc2 + 1, exp);
    end
    tick();
  endtask

  task automatic test_abort();
    logic [7:0] msg[$];
    int pulses;
    data = 8'h01;
    last = 1'b1;
    valid_a = 1'b1;
    tick();
    valid_a = 1'b0;
    last = 1'b0;
    repeat (20) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    // 8 message bits then 12 flush steps: x^12.
    n_cmp++;
    if (busy_a !== 1'b0 || crc_a !== 32'h00001000) begin
      n_err++;
      $display("FAIL abort_flush: busy=%b crc=%h, required 0 00001000", busy_a, crc_a);
    end
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (cv_a) pulses++;
    end
    n_cmp++;
    if (pulses != 0) begin
      n_err++;
      $display("FAIL abort_no_pulse: got %0d pulses, required 0", pulses);
    end
    data = 8'h55;
    last = 1'b1;
    valid_a = 1'b1;
    abort = 1'b1;
    tick();
    valid_a = 1'b0;
    abort = 1'b0;
    last = 1'b0;
    n_cmp++;
    if (busy_a !== 1'b0) begin
      n_err++;
      $display("FAIL abort_discard_accept: busy=%b, required 0", busy_a);
    end
    msg = '{8'h01};
    run_frame(1'b0, msg, 0);
    n_cmp++;
    if (got_timeout || got_crc !== 32'h04C11DB7) begin
      n_err++;
      $display("FAIL abort_next_frame: got %h, required 04c11db7", got_crc);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] msg[$];
    int pulses;
    data = 8'h81;
    last = 1'b1;
    valid_a = 1'b1;
    tick();
    valid_a = 1'b0;
    last = 1'b0;
    repeat (4) tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (busy_a !== 1'b0 || crc_a !== 32'h0) begin
      n_err++;
      $display("FAIL reset_mid_async: busy=%b crc=%h, required 0 00000000", busy_a, crc_a);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (cv_a) pulses++;
    end
    n_cmp++;
    if (pulses != 0) begin
      n_err++;
      $display("FAIL reset_mid_no_pulse: got %0d pulses, required 0", pulses);
    end
    msg = '{8'h02};
    run_frame(1'b0, msg, 0);
    n_cmp++;
    if (got_timeout || got_crc !== 32'h09823B6E) begin
      n_err++;
      $display("FAIL reset_mid_next_frame: got %h, required 09823b6e", got_crc);
    end
  endtask

  task automatic test_random();
    logic [7:0]  msg[$];
    logic [31:0] exp;
    bit          sel;
    int          len;
    int          gap;
    for (int f = 0; f < 24; f++) begin
      sel = 1'($urandom);
      len = int'($urandom_range(1, 5));
      gap = int'($urandom_range(0, 3));
      msg.delete();
      for (int j = 0; j < len; j++) msg.push_back(8'($urandom));
      exp = model_crc(msg, !sel);
      run_frame(sel, msg, gap);
      n_cmp++;
      if (got_timeout || got_crc !== exp) begin
        n_err++;
        $display("FAIL random_crc[%0d] aug=%0d len=%0d: got %h, required %h",
                 f, !sel, len, got_crc, exp);
      end
      n_cmp++;
      if (got_lat != (sel ? 9 : 41)) begin
        n_err++;
        $display("FAIL random_latency[%0d]: got %0d, required %0d", f, got_lat, sel ? 9 : 41);
      end
    end
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    cyc     = 0;
    data    = 8'h00;
    last    = 1'b0;
    abort   = 1'b0;
    valid_a = 1'b0;
    valid_b = 1'b0;
    test_reset();
    test_known();
    test_back_to_back();
    test_no_augment();
    test_stall();
    test_abort();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/crc32_serial_ctrl.md
CRC32_SERIAL_CTRL -- requirements
Module: crc32_serial_ctrl

Interface
REQ-001 Parameter POLYNOMIAL, default 32'h04C11DB7: feedback polynomial, implicit x^32 term.
REQ-002 Parameter INIT, default 32'h0: CRC register value loaded at frame start.
REQ-003 Parameter AUGMENT, default 1: 1 appends 32 zero bits after the last byte; 0 ends the frame with no flush.
REQ-004 i_clk  input  1  clock; all logic is rising-edge.
REQ-005 i_rst_n  input  1  asynchronous, active-low reset.
REQ-006 i_data  input  8  byte to fold into the CRC; sampled on accept.
REQ-007 i_valid  input  1  i_data/i_last are valid.
REQ-008 i_last  input  1  current byte is the final byte of the frame.
REQ-009 o_ready  output  1  block accepts a byte this cycle; accept = i_valid && o_ready.
REQ-010 i_abort  input  1  synchronous frame abort.
REQ-011 o_crc  output  32  CRC register contents; final value is stable while in IDLE.
REQ-012 o_crc_valid  output  1  one-cycle pulse when o_crc holds a completed frame CRC.
REQ-013 o_busy  output  1  high in every state except IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, SHIFT, FLUSH and DONE.
REQ-015 Bit step SHALL be next = {crc[30:0], b} ^ (crc[31] ? POLYNOMIAL : 0): one bit per cycle, no combinational byte-wide unrolling.
REQ-016 Byte bits SHALL be fed MSB first (i_data[7] first).
REQ-017 o_ready SHALL be high in IDLE, and in SHIFT on bit-count 7 when the current byte is not last; it SHALL be low otherwise.
REQ-018 An accept in IDLE SHALL load crc <= INIT and the byte register, clear bit-count, and move to SHIFT.
REQ-019 An accept in SHIFT on bit-count 7 SHALL shift that bit and load the next byte with no bubble, giving 8 cycles/byte throughput.
REQ-020 At bit-count 7 with no accept and the current byte not last, SHALL stay in SHIFT without stepping crc, holding o_ready high until an accept.
REQ-021 After bit 0 of the last byte: go to FLUSH if AUGMENT=1, otherwise go to DONE.
REQ-022 FLUSH SHALL step exactly 32 times with b=0 (6-bit counter 0..31), then go to DONE.
REQ-023 DONE SHALL last one cycle, assert o_crc_valid, leave crc unchanged, and return to IDLE.
REQ-024 i_abort SHALL take priority over all other events in any state: next state IDLE, no o_crc_valid, crc unchanged, and any same-cycle accept discarded.
REQ-025 i_valid while o_ready is low SHALL be ignored; the upstream holds data per valid/ready rules.
REQ-026 A single-byte frame accepted at edge N SHALL produce o_crc_valid at N+41 with AUGMENT=1, and at N+9 with AUGMENT=0.

Reset
REQ-027 On i_rst_n low, SHALL asynchronously set: state IDLE, crc INIT, counters 0, o_crc_valid 0, o_busy 0, o_ready 1 after release.
REQ-028 Reset asserted mid-frame SHALL discard the frame with no o_crc_valid pulse.

Structure
REQ-029 Package crc32_serial_pkg SHALL hold the FSM state enum, the CRC32_POLY constant, and the crc_step(crc, bit, poly) function.
REQ-030 No sub-module SHALL be used: the CRC register lives in this block so that frame-start load of INIT is synchronous, with no reset gating.

Verification
REQ-031 Single byte 0x01, i_last=1, AUGMENT=1 -> o_crc=32'h04C11DB7 with o_crc_valid at accept+41.
REQ-032 Single byte 0x02, last -> o_crc=32'h09823B6E; single byte 0x00 -> o_crc=32'h00000000.
REQ-033 Bytes 0x00 then 0x01, back-to-back with i_valid held -> second accept exactly 8 cycles after the first, o_crc=32'h04C11DB7.
REQ-034 AUGMENT=0, byte 0x01 last -> o_crc=32'h00000001 with o_crc_valid at accept+9.
REQ-035 i_abort during FLUSH, then a new frame with byte 0x01 -> no pulse for the aborted frame; new frame yields 32'h04C11DB7.
REQ-036 Reset pulsed during SHIFT -> o_busy=0 and o_crc=INIT immediately; next frame is correct.
